tag_ctrl: RTL and testbench
===========================

// Module: tag_ctrl
// PURPOSE
//  Initiator-side controller for the 64x22 tag_array SRAM macro of the direct-mapped L1 cache.
//  Accepts lookup/fill/invalidate/flush ops over valid/ready, drives CS/WEB/OE/A/DI, and captures DO one cycle later.
//  Compares the stored tag and returns hit plus the stored tag (for victim writeback) over a held response handshake.
//  Also sweeps the SRAM clean after reset, since the macro has no reset of its own.
// PARAMETERS
//  ADDR_W   32  byte address width; ADDR_W == TAG_W+IDX_W+OFF_W
//  OFF_W    5   line offset bits (32B line)
//  IDX_W    6   index bits; Words = 2**IDX_W = 64
//  TAG_W    21  tag bits; SRAM word = {valid, tag} = TAG_W+1 = 22 bits
// PORTS
//  clk        in   1       single clock; also drives the tag_array CK
//  rst        in   1       synchronous, active-high reset
//  req_valid  in   1       request valid
//  req_ready  out  1       request ready (1 only in IDLE)
//  req_op     in   2       00 lookup, 01 fill, 10 invalidate, 11 flush-all
//  req_addr   in   ADDR_W  byte address: tag=[31:11], idx=[10:5]; ignored for flush
//  rsp_valid  out  1       response valid; held until rsp_ready
//  rsp_ready  in   1       response accept
//  rsp_hit    out  1       lookup: stored valid && stored tag == req tag; other ops: 0
//  rsp_lvalid out  1       lookup: stored valid bit; other ops: 0
//  rsp_tag    out  TAG_W   lookup: stored tag; other ops: 0
//  ta_cs      out  1       SRAM chip select
//  ta_web     out  1       SRAM write enable, active low
//  ta_oe      out  1       SRAM output enable; tied 1
//  ta_a       out  IDX_W   SRAM address
//  ta_di      out  TAG_W+1 SRAM write data {valid, tag}
//  ta_do      in   TAG_W+1 SRAM read data; valid the cycle after the read edge
// BEHAVIOUR
//  States: INIT, IDLE, CMP, RESP, SWEEP.
//  Reset (rst=1 at an edge): state=INIT, sweep counter=0.
//   Reset outputs: rsp_valid=0, rsp_hit=0, rsp_lvalid=0, rsp_tag=0, req_ready=0.
//   Any in-flight op and any held response are dropped.
//  INIT/SWEEP: one write per cycle. ta_cs=1, ta_web=0, ta_di=0, ta_a=counter, counter 0..63.
//   INIT leaves after index 63 -> IDLE.
//   SWEEP leaves after index 63 -> RESP.
//   Exactly 64 write cycles; counter wraps to 0 on exit.
//  IDLE: req_ready=1.
//   SRAM drive is combinational from the request: ta_cs = req_valid; ta_a = req idx;
//   ta_web = 0 for fill/invalidate, 1 for lookup.
//   ta_di = {1, req tag} for fill, 0 for invalidate.
//   Accept edge E0: req_valid && req_ready.
//   On accept: lookup -> CMP (req tag latched); fill/invalidate -> RESP; flush -> SWEEP.
//   Flush issues no SRAM access in IDLE; its first write is in SWEEP.
//  CMP: ta_cs=0; ta_do is valid.
//   At the next edge E1, register rsp_hit, rsp_lvalid and rsp_tag -> RESP.
//   Lookup latency: rsp_valid is first high in the cycle after E1, 2 cycles after E0.
//  RESP: rsp_valid=1; all rsp_* fields stable.
//   rsp_valid && rsp_ready at an edge -> IDLE.
//   No new request accepted until then; one response per accepted op, in order.
//  Outside IDLE/INIT/SWEEP: ta_cs=0, ta_web=1, ta_a=0, ta_di=0.
//  A fill that hits an existing valid line just overwrites it; no error.
//  A lookup to the index just filled returns the new contents (the write completes at E0).
// TESTING
//  T1 reset: rst high 1 cycle -> 64 consecutive cycles ta_cs=1, ta_web=0, ta_di=0, ta_a=0..63;
//     req_ready=1 in the 65th cycle; rsp_valid=0 throughout.
//  T2 lookup 0x0000_1040 after init -> ta_a=2, ta_web=1; rsp 2 cycles later: hit=0, lvalid=0, tag=0.
//  T3 fill 0x0000_1040 -> ta_a=2, ta_web=0, ta_di=0x200002; then:
//     lookup 0x0000_1044 -> hit=1, tag=0x2;
//     lookup 0x0000_1840 -> hit=0, lvalid=1, tag=0x2.
//  T4 hold rsp_ready=0 for 5 cycles on a lookup rsp -> rsp_valid and fields stable, req_ready=0,
//     ta_cs=0; release -> IDLE next cycle.
//  T5 invalidate 0x0000_1040 then lookup -> hit=0, lvalid=0.
//     flush -> 64 writes idx 0..63 then rsp_valid with hit=0.
//  T6 assert rst at sweep index 30 of a flush -> no rsp; INIT restarts at idx 0, 64 writes, then IDLE.

Source files
------------

// File: rtl/tag_ctrl.sv
// Initiator-side controller for the direct-mapped L1 tag_array SRAM (64 x {valid, tag}).
// Handles lookup/fill/invalidate/flush requests, clears the macro after reset, and holds each response until accepted.
module tag_ctrl #(
  parameter int ADDR_W = 32,
  parameter int OFF_W  = 5,
  parameter int IDX_W  = 6,
  parameter int TAG_W  = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic              rsp_lvalid,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              ta_cs,
  output logic              ta_web,
  output logic              ta_oe,
  output logic [IDX_W-1:0]  ta_a,
  output logic [TAG_W:0]    ta_di,
  input  logic [TAG_W:0]    ta_do
);

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_FILL   = 2'b01;
  localparam logic [1:0] OP_INVAL  = 2'b10;
  localparam logic [1:0] OP_FLUSH  = 2'b11;

  typedef enum logic [2:0] {INIT, IDLE, CMP, RESP, SWEEP} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   cnt_reg, cnt_next;
  logic [TAG_W-1:0]   cmp_tag_reg;
  logic               rsp_hit_reg, rsp_lvalid_reg;
  logic [TAG_W-1:0]   rsp_tag_reg;
  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   tag_eq;
  logic               accept;
  logic               unused_off;

  assign req_tag    = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx    = req_addr[OFF_W +: IDX_W];
  assign unused_off = ^req_addr[OFF_W-1:0];
  assign accept     = req_valid && (state_reg == IDLE);
  assign ta_oe      = 1'b1;

  // Per-bit tag match against the word read during CMP.
  generate
    for (genvar gi = 0; gi < TAG_W; gi++) begin : g_tag_eq
      assign tag_eq[gi] = (ta_do[gi] == cmp_tag_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    ta_cs      = 1'b0;
    ta_web     = 1'b1;
    ta_a       = '0;
    ta_di      = '0;
    case (state_reg)
      INIT, SWEEP: begin
        ta_cs    = 1'b1;
        ta_web   = 1'b0;
        ta_a     = cnt_reg;
        // Counter wraps back to 0 on the last index, ready for the next sweep.
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == {IDX_W{1'b1}}) begin
          state_next = (state_reg == INIT) ? IDLE : RESP;
        end
      end
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          case (req_op)
            OP_LOOKUP: begin
              ta_cs      = 1'b1;
              ta_a       = req_idx;
              state_next = CMP;
            end
            OP_FILL: begin
              ta_cs      = 1'b1;
              ta_web     = 1'b0;
              ta_a       = req_idx;
              ta_di      = {1'b1, req_tag};
              state_next = RESP;
            end
            OP_INVAL: begin
              ta_cs      = 1'b1;
              ta_web     = 1'b0;
              ta_a       = req_idx;
              state_next = RESP;
            end
            OP_FLUSH: begin
              state_next = SWEEP;
            end
            default: state_next = IDLE;
          endcase
        end
      end
      CMP: begin
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = INIT;
    endcase
  end

  // Response fields are cleared on every accept so non-lookup ops report zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_tag_reg    <= '0;
      rsp_hit_reg    <= 1'b0;
      rsp_lvalid_reg <= 1'b0;
      rsp_tag_reg    <= '0;
    end else if (accept) begin
      cmp_tag_reg    <= req_tag;
      rsp_hit_reg    <= 1'b0;
      rsp_lvalid_reg <= 1'b0;
      rsp_tag_reg    <= '0;
    end else if (state_reg == CMP) begin
      rsp_hit_reg    <= ta_do[TAG_W] && (&tag_eq);
      rsp_lvalid_reg <= ta_do[TAG_W];
      rsp_tag_reg    <= ta_do[TAG_W-1:0];
    end
  end

  assign rsp_hit    = rsp_hit_reg;
  assign rsp_lvalid = rsp_lvalid_reg;
  assign rsp_tag    = rsp_tag_reg;

endmodule

// File: tb/tb_tag_ctrl.sv
// Bench for tag_ctrl: behavioural tag_array macro, table-driven directed ops, reset-during-flush,
// and random ops checked against a per-index {valid, tag} reference memory.
module tb_tag_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_hit;
  logic        rsp_lvalid;
  logic [20:0] rsp_tag;
  logic        ta_cs;
  logic        ta_web;
  logic        ta_oe;
  logic [5:0]  ta_a;
  logic [21:0] ta_di;
  logic [21:0] ta_do;

  tag_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_lvalid(rsp_lvalid), .rsp_tag(rsp_tag),
    .ta_cs(ta_cs), .ta_web(ta_web), .ta_oe(ta_oe), .ta_a(ta_a), .ta_di(ta_di), .ta_do(ta_do)
  );

  always #5 clk = ~clk;

  // Behavioural macro: write at the edge, read data appears after the read edge.
  logic [21:0] sram [64];
  always @(posedge clk) begin
    if (ta_cs) begin
      if (!ta_web) sram[ta_a] <= ta_di;
      else         ta_do <= sram[ta_a];
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: one {valid, tag} word per index.
  logic [21:0] ref_mem [64];

  task automatic model_clear();
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
  endtask

  task automatic model_op(input logic [1:0] op, input logic [31:0] addr,
                          output logic h, output logic lv, output logic [20:0] tg);
    int idx;
    logic [20:0] t;
    idx = int'(addr / 32) % 64;
    t   = 21'(addr / 2048);
    h = 1'b0; lv = 1'b0; tg = '0;
    case (op)
      2'd0: begin
        lv = ref_mem[idx][21];
        tg = ref_mem[idx][20:0];
        h  = lv && (tg == t);
      end
      2'd1: ref_mem[idx] = {1'b1, t};
      2'd2: ref_mem[idx] = '0;
      default: model_clear();
    endcase
  endtask

  // 64 clearing writes starting now, then IDLE; called one cycle after reset is released.
  task automatic check_init();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk("init_cs", ta_cs, 1);
      chk("init_web", ta_web, 0);
      chk("init_di", ta_di, 0);
      chk("init_a", ta_a, i);
      chk("init_rsp_valid", rsp_valid, 0);
      chk("init_req_ready", req_ready, 0);
      if (i == 0) begin
        chk("rst_rsp_hit", rsp_hit, 0);
        chk("rst_rsp_lvalid", rsp_lvalid, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("ta_oe", ta_oe, 1);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("init_done_req_ready", req_ready, 1);
    chk("init_done_rsp_valid", rsp_valid, 0);
    $display("init sweep: 64 writes checked");
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] addr, input int hold,
                        output logic h, output logic lv, output logic [20:0] tg);
    int n;
    int exp_lat;
    logic [5:0] idx;
    logic [20:0] t;
    idx = addr[10:5];
    t   = addr[31:11];
    exp_lat = (op == 2'd0) ? 2 : (op == 2'd3) ? 65 : 1;
    @(posedge clk); #1;
    req_op = op; req_addr = addr; req_valid = 1'b1;
    @(negedge clk);
    chk("req_ready", req_ready, 1);
    chk("req_cs", ta_cs, (op != 2'd3) ? 1 : 0);
    if (op != 2'd3) begin
      chk("req_a", ta_a, idx);
      chk("req_web", ta_web, (op == 2'd0) ? 1 : 0);
    end
    if (op == 2'd1) chk("req_di_fill", ta_di, {1'b1, t});
    if (op == 2'd2) chk("req_di_inval", ta_di, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (op == 2'd3 && n < 64) begin
        chk("sweep_cs", ta_cs, 1);
        chk("sweep_web", ta_web, 0);
        chk("sweep_di", ta_di, 0);
        chk("sweep_a", ta_a, n);
      end
      if (op == 2'd0 && n == 0) chk("cmp_cs", ta_cs, 0);
      if (rsp_valid) break;
      if (n > 200) begin
        n_checks++; n_fail++;
        $display("FAIL rsp_timeout: no rsp_valid after %0d cycles, expected within %0d", n, exp_lat);
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n + 1, exp_lat);
    h = rsp_hit; lv = rsp_lvalid; tg = rsp_tag;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_hit", rsp_hit, h);
      chk("hold_lvalid", rsp_lvalid, lv);
      chk("hold_tag", rsp_tag, tg);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_cs", ta_cs, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_req_ready", req_ready, 1);
    $display("op=%0d addr=0x%08h hold=%0d -> hit=%0b lvalid=%0b tag=0x%06h lat=%0d",
             op, addr, hold, h, lv, tg, n + 1);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    int          hold;
    logic        exp_hit;
    logic        exp_lvalid;
    logic [20:0] exp_tag;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic h, lv, mh, mlv;
    logic [20:0] tg, mtg;
    logic [1:0] op;
    logic [31:0] addr;
    int r;

    vecs[0]  = '{2'd0, 32'h0000_1040, 0, 1'b0, 1'b0, 21'h0};
    vecs[1]  = '{2'd1, 32'h0000_1040, 0, 1'b0, 1'b0, 21'h0};
    vecs[2]  = '{2'd0, 32'h0000_1044, 0, 1'b1, 1'b1, 21'h2};
    vecs[3]  = '{2'd0, 32'h0000_1840, 5, 1'b0, 1'b1, 21'h2};
    vecs[4]  = '{2'd2, 32'h0000_1040, 0, 1'b0, 1'b0, 21'h0};
    vecs[5]  = '{2'd0, 32'h0000_1040, 1, 1'b0, 1'b0, 21'h0};
    vecs[6]  = '{2'd1, 32'hFFFF_FFE0, 0, 1'b0, 1'b0, 21'h0};
    vecs[7]  = '{2'd0, 32'hFFFF_FFFF, 0, 1'b1, 1'b1, 21'h1FFFFF};
    vecs[8]  = '{2'd1, 32'h0000_0000, 2, 1'b0, 1'b0, 21'h0};
    vecs[9]  = '{2'd0, 32'h0000_001F, 0, 1'b1, 1'b1, 21'h0};
    vecs[10] = '{2'd1, 32'h0000_1840, 0, 1'b0, 1'b0, 21'h0};
    vecs[11] = '{2'd0, 32'h0000_1840, 0, 1'b1, 1'b1, 21'h3};
    vecs[12] = '{2'd3, 32'h0000_0000, 3, 1'b0, 1'b0, 21'h0};
    vecs[13] = '{2'd0, 32'hFFFF_FFE0, 0, 1'b0, 1'b0, 21'h0};

    // Reset and power-up sweep
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    check_init();

    // Directed table
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].addr, vecs[i].hold, h, lv, tg);
      model_op(vecs[i].op, vecs[i].addr, mh, mlv, mtg);
      chk($sformatf("vec%0d_hit", i), h, vecs[i].exp_hit);
      chk($sformatf("vec%0d_lvalid", i), lv, vecs[i].exp_lvalid);
      chk($sformatf("vec%0d_tag", i), tg, vecs[i].exp_tag);
    end

    // Reset in the middle of a flush sweep
    run_op(2'd1, 32'h0000_2060, 0, h, lv, tg);
    model_op(2'd1, 32'h0000_2060, mh, mlv, mtg);
    @(posedge clk); #1;
    req_op = 2'd3; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("flush_sweep_a", ta_a, i);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("flush_at_idx30", ta_a, 30);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    check_init();
    run_op(2'd0, 32'h0000_2060, 0, h, lv, tg);
    chk("after_rst_lookup_lvalid", lv, 0);
    chk("after_rst_lookup_hit", h, 0);

    // Random ops against the reference memory
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      op = (r < 45) ? 2'd0 : (r < 75) ? 2'd1 : (r < 94) ? 2'd2 : 2'd3;
      addr = {19'($urandom_range(0, 0)), 2'($urandom_range(0, 3)), 3'b000,
              3'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
      if ($urandom_range(0, 9) == 0) addr[31:11] = 21'($urandom);
      run_op(op, addr, $urandom_range(0, 3), h, lv, tg);
      model_op(op, addr, mh, mlv, mtg);
      chk("rand_hit", h, mh);
      chk("rand_lvalid", lv, mlv);
      chk("rand_tag", tg, mtg);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
